// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity constants and baud helper
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period down counter with full and half reload, ticks one cycle before expiry
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (half) cnt <= W'(CLKS_PER_BIT / 2);
    else if (load) cnt <= W'(CLKS_PER_BIT);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tick = cnt == W'(1);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with one-deep holding register and error flags
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam bit HAS_PAR = PARITY != PARITY_NONE;
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx_param: CLK_FREQ/BAUD too small");
  end
  uart_state_e state, nxt;
  logic rx_m, rx_s, rx_prev;
  logic tick, start_det, last_data, last_stop, frame_done, par_exp;
  logic ferr_acc, perr_acc;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_m, rx_s, rx_prev} <= 3'b110;
    else {rx_m, rx_s, rx_prev} <= {rxd, rx_m, rx_s};
  assign start_det  = state == ST_IDLE && !rx_s && rx_prev;
  assign last_data  = bit_idx == 4'(DATA_BITS - 1);
  assign last_stop  = bit_idx == 4'(STOP_BITS - 1);
  assign frame_done = state == ST_STOP && tick && last_stop;
  assign par_exp    = ^shreg ^ (PARITY == PARITY_ODD);
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk (clk),
    .rst (rst),
    .load(tick && nxt != ST_IDLE && nxt != ST_WAIT_HIGH),
    .half(start_det),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      nxt = start_det ? ST_START : ST_IDLE;
      ST_START:     if (tick) nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (tick && last_data) nxt = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (tick) nxt = ST_STOP;
      ST_STOP:      if (frame_done) nxt = (ferr_acc || !rx_s) ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (rx_s) nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end
  always_comb busy = state != ST_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg    <= '0;
      bit_idx  <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else if (state == ST_IDLE) begin
      bit_idx  <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else if (tick) begin
      if (state == ST_DATA) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= last_data ? '0 : bit_idx + 1'b1;
      end
      if (state == ST_PARITY) perr_acc <= rx_s != par_exp;
      if (state == ST_STOP) begin
        bit_idx  <= bit_idx + 1'b1;
        ferr_acc <= ferr_acc | ~rx_s;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        frame_err  <= ferr_acc | ~rx_s;
        parity_err <= perr_acc;
        rx_valid   <= 1'b1;
      end else if (frame_done) overrun_err <= 1'b1;
      else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL expose parameter CLK_FREQ, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL expose parameter BAUD, default 115200, meaning line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, rounded to nearest.
REQ-003 SHALL expose parameter DATA_BITS, default 8, meaning payload width; legal range 5..9.
REQ-004 SHALL expose parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL expose parameter STOP_BITS, default 1, meaning number of stop bits checked; legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port rxd, input, 1 bit, asynchronous serial line; idles high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits, received payload, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1 bit, meaning rx_data/flags hold an unconsumed frame.
REQ-011 SHALL have port rx_ready, input, 1 bit, consumer accepts the frame when rx_valid and rx_ready are both high.
REQ-012 SHALL have port frame_err, output, 1 bit, stop-bit failure for the held frame; valid with rx_valid.
REQ-013 SHALL have port parity_err, output, 1 bit, parity mismatch for the held frame; always 0 when PARITY = 0.
REQ-014 SHALL have port overrun_err, output, 1 bit, one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-016 SHALL pass rxd through a 2-flop synchroniser (reset value 1); all decisions use the synchronised signal.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; PARITY is skipped when PARITY = 0.
REQ-018 SHALL leave IDLE for START on a synchronised 1->0 transition and load the bit counter with CLKS_PER_BIT/2.
REQ-019 SHALL sample at START mid-bit; a high sample is a glitch and returns to IDLE with no output or flag.
REQ-020 SHALL sample each data bit at successive CLKS_PER_BIT intervals after the start mid-point, shifting LSB first.
REQ-021 SHALL compare the parity sample against the XOR of the data bits (odd: XOR^1) and latch parity_err on mismatch.
REQ-022 SHALL check each of the STOP_BITS stop samples; any low sample sets frame_err.
REQ-023 SHALL, when frame_err is set, deliver the frame and then enter WAIT_HIGH, staying there until the synchronised rxd is high (break handling).
REQ-024 SHALL update rx_data, frame_err and parity_err, and set rx_valid, on the cycle after the final stop sample.
REQ-025 SHALL hold rx_data and the flags stable while rx_valid is high; rx_valid clears on the cycle after acceptance.
REQ-026 SHALL, if a frame completes while rx_valid is high and rx_ready is low, drop the new frame, keep the held data, and pulse overrun_err for 1 cycle.
REQ-027 SHALL, if a frame completes in the same cycle that rx_ready accepts the held frame, load the new frame, keep rx_valid high, and not pulse overrun_err.
REQ-028 SHALL continue receiving while rx_valid is high; the holding register is one entry deep.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, all counters to 0, synchroniser flops to 1, rx_data to 0, and rx_valid, frame_err, parity_err, overrun_err and busy to 0.
REQ-030 SHALL discard any partially received frame when rst asserts mid-frame; after release, reception restarts only on a fresh falling edge.

Structure
REQ-031 SHALL take the state encoding and the PARITY_NONE/ODD/EVEN constants from the shared package uart_pkg.
REQ-032 SHALL place the bit-period counter in a sub-module uart_baud_cnt (load, half-load, tick out), reusable by the transmitter.
REQ-033 SHALL reject illegal DATA_BITS, PARITY or STOP_BITS values at elaboration.

Verification (CLK_FREQ = 50_000_000, BAUD = 5_000_000, so CLKS_PER_BIT = 10)
REQ-034 SHALL check: 8N1 frame 0xA5, rx_ready held high -> rx_data = 0xA5, no flags, rx_valid high exactly 98 clocks after the rxd falling edge, for 1 cycle.
REQ-035 SHALL check: PARITY = 2, frame 0x3C sent with wrong parity bit 1 -> rx_data = 0x3C, parity_err = 1; with correct parity 0 -> parity_err = 0.
REQ-036 SHALL check: frame 0x55 with stop bit 0, then rxd held low for 30 bit times -> one frame with frame_err = 1; no second frame; reception resumes after rxd goes high.
REQ-037 SHALL check: rx_ready low, frames 0x11 then 0x22 -> rx_data stays 0x11 and overrun_err pulses once; with rx_ready raised on the completion cycle of 0x22 -> rx_data = 0x22 and no overrun.
REQ-038 SHALL check: rxd low pulse of 3 clocks -> no rx_valid and busy returns low; rst pulsed during the data bits of 0xF0 -> all outputs 0 and no frame is delivered.
